// File: rtl/tbird_signal_ctrl.sv
// Thunderbird turn-indicator front-end controller.
// Debounces the stalk/hazard switches, arbitrates them against one-shot
// lane-change requests, and produces the sequencer's mode levels, step
// tick and step index. Lane-change flashing cancels itself after a fixed
// number of full 4-step sequences.
module tbird_signal_ctrl #(
    parameter int TICK_DIV     = 25000000,
    parameter int DEB_LEN      = 4,
    parameter int LANE_FLASHES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic       sw_haz,
    input  logic       lane_left_req,
    input  logic       lane_right_req,
    output logic       left,
    output logic       right,
    output logic       haz,
    output logic       step_en,
    output logic [2:0] mode,
    output logic [1:0] seq_step
);

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_LEFT   = 3'd1,
        MODE_RIGHT  = 3'd2,
        MODE_LANE_L = 3'd3,
        MODE_LANE_R = 3'd4,
        MODE_HAZ    = 3'd5
    } mode_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEB_LEN + 1);
    localparam int FW = $clog2(LANE_FLASHES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_LEN - 1);
    localparam logic [FW-1:0] FLASH_DONE = FW'(LANE_FLASHES);

    // Switch bit order used throughout: [0]=left, [1]=right, [2]=hazard.
    logic [2:0]    raw_s;
    logic [2:0]    deb_r;
    logic [DW-1:0] deb_cnt_r [3];

    mode_t         mode_r;
    mode_t         mode_next_s;
    logic          lane_acc_s;
    logic          restart_s;
    logic [PW-1:0] presc_r;
    logic [1:0]    seq_r;
    logic [FW-1:0] flash_r;

    assign raw_s = {sw_haz, sw_right, sw_left};

    // Debounce each switch: a disagreement must persist DEB_LEN cycles to flip the accepted value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_r[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (raw_s[i] != deb_r[i]) begin
                    if (deb_cnt_r[i] == DEB_LAST) begin
                        deb_r[i]     <= raw_s[i];
                        deb_cnt_r[i] <= {DW{1'b0}};
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
                    end
                end else begin
                    deb_cnt_r[i] <= {DW{1'b0}};
                end
            end
        end
    end

    // Priority arbitration: hazard, then a single stalk, then lane requests, then lane hold/cancel.
    always_comb begin
        mode_next_s = MODE_OFF;
        lane_acc_s  = 1'b0;
        if (deb_r[2]) begin
            mode_next_s = MODE_HAZ;
        end else if (deb_r[0] ^ deb_r[1]) begin
            mode_next_s = deb_r[0] ? MODE_LEFT : MODE_RIGHT;
        end else if (lane_left_req && !lane_right_req) begin
            mode_next_s = MODE_LANE_L;
            lane_acc_s  = 1'b1;
        end else if (lane_right_req && !lane_left_req) begin
            mode_next_s = MODE_LANE_R;
            lane_acc_s  = 1'b1;
        end else begin
            case (mode_r)
                MODE_LANE_L, MODE_LANE_R: begin
                    mode_next_s = (flash_r == FLASH_DONE) ? MODE_OFF : mode_r;
                end
                default: begin
                    mode_next_s = MODE_OFF;
                end
            endcase
        end
    end

    // An accepted lane request restarts timing even when the mode itself is unchanged.
    assign restart_s = (mode_next_s != mode_r) || lane_acc_s;

    // Register mode, decoded levels, and the prescaler / step / flash counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r  <= MODE_OFF;
            left    <= 1'b0;
            right   <= 1'b0;
            haz     <= 1'b0;
            step_en <= 1'b0;
            presc_r <= {PW{1'b0}};
            seq_r   <= 2'd0;
            flash_r <= {FW{1'b0}};
        end else begin
            mode_r <= mode_next_s;
            left   <= (mode_next_s == MODE_LEFT)  || (mode_next_s == MODE_LANE_L);
            right  <= (mode_next_s == MODE_RIGHT) || (mode_next_s == MODE_LANE_R);
            haz    <= (mode_next_s == MODE_HAZ);
            if (restart_s || (mode_next_s == MODE_OFF)) begin
                presc_r <= {PW{1'b0}};
                seq_r   <= 2'd0;
                flash_r <= {FW{1'b0}};
                step_en <= 1'b0;
            end else if (presc_r == PRESC_LAST) begin
                presc_r <= {PW{1'b0}};
                step_en <= 1'b1;
                seq_r   <= seq_r + 2'd1;
                if ((seq_r == 2'd3) &&
                    ((mode_r == MODE_LANE_L) || (mode_r == MODE_LANE_R))) begin
                    flash_r <= flash_r + FW'(1);
                end else begin
                    flash_r <= flash_r;
                end
            end else begin
                presc_r <= presc_r + PW'(1);
                step_en <= 1'b0;
            end
        end
    end

    assign mode     = mode_r;
    assign seq_step = seq_r;

endmodule

// File: tb/tb_tbird_signal_ctrl.sv
// Self-checking bench for tbird_signal_ctrl with a time-since-mode-entry reference model.
module tb_tbird_signal_ctrl;

    localparam int TD = 4;
    localparam int DL = 2;
    localparam int LF = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw_left, sw_right, sw_haz;
    logic       lane_left_req, lane_right_req;
    logic       left, right, haz, step_en;
    logic [2:0] mode;
    logic [1:0] seq_step;

    int total = 0;
    int bad   = 0;

    // Reference model state: debounced values, mismatch run lengths, mode, cycles since entry.
    int m_deb [3] = '{0, 0, 0};
    int m_run [3] = '{0, 0, 0};
    int m_mode    = 0;
    int m_t       = 0;

    tbird_signal_ctrl #(.TICK_DIV(TD), .DEB_LEN(DL), .LANE_FLASHES(LF)) dut (
        .clk(clk), .reset(reset),
        .sw_left(sw_left), .sw_right(sw_right), .sw_haz(sw_haz),
        .lane_left_req(lane_left_req), .lane_right_req(lane_right_req),
        .left(left), .right(right), .haz(haz), .step_en(step_en),
        .mode(mode), .seq_step(seq_step)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_deb[i] = 0;
            m_run[i] = 0;
        end
        m_mode = 0;
        m_t    = 0;
    endtask

    // One clock edge of the reference model, evaluated from the inputs present at that edge.
    task automatic model_step();
        int nm;
        bit acc;
        int raw [3];
        if (reset) begin
            model_reset();
            return;
        end
        acc = 1'b0;
        if (m_deb[2] != 0)                    nm = 5;
        else if (m_deb[0] != m_deb[1])        nm = (m_deb[0] != 0) ? 1 : 2;
        else if (lane_left_req && !lane_right_req) begin nm = 3; acc = 1'b1; end
        else if (lane_right_req && !lane_left_req) begin nm = 4; acc = 1'b1; end
        else if ((m_mode == 3 || m_mode == 4) && m_t < 4 * TD * LF) nm = m_mode;
        else                                  nm = 0;
        if (nm != m_mode || acc) m_t = 0;
        else if (nm != 0)        m_t = m_t + 1;
        m_mode = nm;
        raw[0] = int'(sw_left);
        raw[1] = int'(sw_right);
        raw[2] = int'(sw_haz);
        for (int i = 0; i < 3; i++) begin
            if (raw[i] != m_deb[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DL) begin
                    m_deb[i] = raw[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("mode", mode, m_mode);
        check("left", left, (m_mode == 1 || m_mode == 3) ? 1 : 0);
        check("right", right, (m_mode == 2 || m_mode == 4) ? 1 : 0);
        check("haz", haz, (m_mode == 5) ? 1 : 0);
        check("step_en", step_en, (m_mode != 0 && m_t > 0 && (m_t % TD) == 0) ? 1 : 0);
        check("seq_step", seq_step, (m_mode != 0) ? ((m_t / TD) % 4) : 0);
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse(input bit l, input bit r);
        lane_left_req  = l;
        lane_right_req = r;
        cycle();
        lane_left_req  = 1'b0;
        lane_right_req = 1'b0;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!step_en && n < 20);
    endtask

    initial begin
        int n;
        int pulses;
        bit done;
        int exp_seq [4];
        exp_seq = '{1, 2, 3, 0};

        reset = 1'b1;
        sw_left = 1'b0; sw_right = 1'b0; sw_haz = 1'b0;
        lane_left_req = 1'b0; lane_right_req = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        check("reset_mode", mode, 0);
        check("reset_step", step_en, 0);

        // Glitch shorter than the debounce window is ignored.
        sw_left = 1'b1;
        cycle();
        sw_left = 1'b0;
        repeat (5) cycle();
        check("glitch_mode", mode, 0);

        // Held stalk: latency, tick spacing and step index sequence.
        sw_left = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!left && n < 10);
        check("deb_latency", n, 3);
        check("left_mode", mode, 1);
        for (int k = 0; k < 4; k++) begin
            wait_step(n);
            check("tick_gap", n, 4);
            check("seq_at_tick", seq_step, exp_seq[k]);
        end

        // Asynchronous reset in the middle of LEFT.
        cycle();
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("arst_mode", mode, 0);
        check("arst_left", left, 0);
        check("arst_step", step_en, 0);
        check("arst_seq", seq_step, 0);
        sw_left = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (6) cycle();
        check("post_reset_left", left, 0);
        check("post_reset_mode", mode, 0);

        // Priority: hazard overrides a stalk, stalk returns, both stalks cancel.
        sw_right = 1'b1;
        repeat (4) cycle();
        check("right_mode", mode, 2);
        sw_haz = 1'b1;
        repeat (3) cycle();
        check("haz_mode", mode, 5);
        check("haz_level", haz, 1);
        check("haz_right", right, 0);
        wait_step(n);
        check("haz_first_tick", n, 4);
        sw_haz = 1'b0;
        repeat (3) cycle();
        check("back_right", mode, 2);
        sw_left = 1'b1;
        repeat (3) cycle();
        check("both_stalks", mode, 0);
        sw_left = 1'b0;
        sw_right = 1'b0;
        repeat (4) cycle();

        // Lane change auto-cancel after LF full sequences.
        pulse(1'b1, 1'b0);
        check("lane_l_mode", mode, 3);
        check("lane_l_left", left, 1);
        pulses = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            cycle();
            if (step_en) pulses++;
            if (pulses == 4 * LF) begin
                cycle();
                check("cancel_mode", mode, 0);
                check("cancel_left", left, 0);
                done = 1'b1;
            end
        end
        check("lane_pulses", pulses, 8);
        repeat (10) cycle();

        // Opposite-direction restart after three ticks.
        pulse(1'b1, 1'b0);
        pulses = 0;
        for (int i = 0; i < 40 && pulses < 3; i++) begin
            cycle();
            if (step_en) pulses++;
        end
        check("pre_restart_ticks", pulses, 3);
        pulse(1'b0, 1'b1);
        check("restart_mode", mode, 4);
        check("restart_seq", seq_step, 0);
        pulses = 0;
        for (int i = 0; i < 80 && mode != 3'd0; i++) begin
            cycle();
            if (step_en) pulses++;
        end
        check("restart_pulses", pulses, 8);
        check("restart_end", mode, 0);

        // Simultaneous requests from OFF are ignored.
        pulse(1'b1, 1'b1);
        cycle();
        check("dual_req", mode, 0);

        // Lane request while a stalk is held is dropped.
        sw_left = 1'b1;
        repeat (4) cycle();
        pulse(1'b0, 1'b1);
        cycle();
        check("req_under_stalk", mode, 1);
        sw_left = 1'b0;
        repeat (4) cycle();
        check("stalk_released", mode, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) sw_left  = ~sw_left;
            if ($urandom_range(0, 24) == 0) sw_right = ~sw_right;
            if ($urandom_range(0, 60) == 0) sw_haz   = ~sw_haz;
            lane_left_req  = ($urandom_range(0, 40) == 0);
            lane_right_req = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 1500) == 0) reset = 1'b1;
            else reset = 1'b0;
            cycle();
        end
        reset = 1'b0;
        lane_left_req = 1'b0;
        lane_right_req = 1'b0;
        repeat (5) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
